alarm_trigger: RTL and testbench

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_trigger.sv | 89 ++++++++
 tb/tb_alarm_trigger.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// alarm_trigger: 24h clock with a settable alarm, mode control and a registered alarm-match flag.
module alarm_trigger #(
   parameter int unsigned CLK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_hour,
   input  logic       inc_min,
   input  logic       alarm_en_btn,
   output logic [4:0] cur_hour,
   output logic [5:0] cur_min,
   output logic [5:0] cur_sec,
   output logic [4:0] alm_hour,
   output logic [5:0] alm_min,
   output logic [1:0] mode,
   output logic       alarm_on,
   output logic       alarm_trig
);
   typedef enum logic [1:0] {RUN = 2'b00, SET_TIME = 2'b01, SET_ALARM = 2'b10, BAD = 2'b11} mode_t;
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
   mode_t         mode_q, mode_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [4:0]    hour_q, hour_d, alm_hour_q, alm_hour_d;
   logic [5:0]    min_q, min_d, sec_q, sec_d, alm_min_q, alm_min_d;
   logic          on_q, on_d, trig_q, trig_d, tick;
   always_comb begin
      mode_d = (mode_q == BAD) ? RUN : !mode_btn ? mode_q :
               (mode_q == RUN) ? SET_TIME : (mode_q == SET_TIME) ? SET_ALARM : RUN;
      tick   = (pre_q == LAST);
      pre_d  = (mode_d == SET_TIME || tick) ? '0 : pre_q + 1'b1;
      on_d   = on_q ^ alarm_en_btn;
      trig_d = (hour_q == alm_hour_q) && (min_q == alm_min_q) && (mode_q != SET_TIME);
   end
   // Pulses act on the current mode; entering SET_TIME zeroes seconds on the same edge.
   always_comb begin
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      alm_hour_d = alm_hour_q;
      alm_min_d  = alm_min_q;
      if (tick) begin
         sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
         if (sec_q == 6'd59) min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
         if (sec_q == 6'd59 && min_q == 6'd59) hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
      end
      if (mode_q == SET_TIME) begin
         if (inc_hour) hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
         if (inc_min) min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
      end
      if (mode_q == SET_ALARM) begin
         if (inc_hour) alm_hour_d = (alm_hour_q == 5'd23) ? '0 : alm_hour_q + 5'd1;
         if (inc_min) alm_min_d = (alm_min_q == 6'd59) ? '0 : alm_min_q + 6'd1;
      end
      if (mode_d == SET_TIME) sec_d = '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= RUN;
         pre_q      <= '0;
         hour_q     <= '0;
         min_q      <= '0;
         sec_q      <= '0;
         alm_hour_q <= 5'd6;
         alm_min_q  <= '0;
         on_q       <= 1'b0;
         trig_q     <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         pre_q      <= pre_d;
         hour_q     <= hour_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         alm_hour_q <= alm_hour_d;
         alm_min_q  <= alm_min_d;
         on_q       <= on_d;
         trig_q     <= trig_d;
      end
   end
   assign cur_hour   = hour_q;
   assign cur_min    = min_q;
   assign cur_sec    = sec_q;
   assign alm_hour   = alm_hour_q;
   assign alm_min    = alm_min_q;
   assign mode       = mode_q;
   assign alarm_on   = on_q;
   assign alarm_trig = trig_q;
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed stimulus with a seconds-of-day reference model checked every cycle.
module tb_alarm_trigger;
   localparam logic [4:0] RST = 5'b10000, MB = 5'b01000, IH = 5'b00100, IM = 5'b00010, EN = 5'b00001;
   logic       clk = 1'b0;
   logic       reset = 1'b0, mode_btn = 1'b0, inc_hour = 1'b0, inc_min = 1'b0, alarm_en_btn = 1'b0;
   logic [4:0] cur_hour, alm_hour;
   logic [5:0] cur_min, cur_sec, alm_min;
   logic [1:0] mode;
   logic       alarm_on, alarm_trig;
   int         n_tests = 0, n_fail = 0;
   int         m_pre, m_secs, m_alm, m_mode, nm, h, mi;
   bit         m_on, m_trig, m_valid = 1'b0;

   alarm_trigger #(.CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_hour(inc_hour), .inc_min(inc_min),
      .alarm_en_btn(alarm_en_btn), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .alm_hour(alm_hour), .alm_min(alm_min), .mode(mode), .alarm_on(alarm_on), .alarm_trig(alarm_trig)
   );

   always #5 clk = ~clk;

   // Reference: time as seconds of day, alarm as minutes of day.
   always @(posedge clk) begin
      if (reset) begin
         m_pre = 0; m_secs = 0; m_alm = 360; m_mode = 0; m_on = 0; m_trig = 0; m_valid = 1;
      end else begin
         nm = (m_mode == 3) ? 0 : mode_btn ? (m_mode + 1) % 3 : m_mode;
         m_trig = (m_secs / 60 == m_alm) && (m_mode != 1);
         if (m_pre == 3 && m_mode != 1) m_secs = (m_secs + 1) % 86400;
         h = m_secs / 3600;
         mi = (m_secs / 60) % 60;
         if (m_mode == 1)
            m_secs = ((h + int'(inc_hour)) % 24) * 3600 + ((mi + int'(inc_min)) % 60) * 60 + m_secs % 60;
         if (m_mode == 2)
            m_alm = ((m_alm / 60 + int'(inc_hour)) % 24) * 60 + (m_alm % 60 + int'(inc_min)) % 60;
         if (nm == 1) begin
            m_secs = m_secs - m_secs % 60;
            m_pre = 0;
         end else m_pre = (m_pre + 1) % 4;
         m_on = m_on ^ alarm_en_btn;
         m_mode = nm;
      end
   end

   task automatic cmp();
      if (!m_valid) return;
      n_tests++;
      if (int'(cur_hour) != m_secs / 3600 || int'(cur_min) != (m_secs / 60) % 60 ||
          int'(cur_sec) != m_secs % 60 || int'(alm_hour) != m_alm / 60 || int'(alm_min) != m_alm % 60 ||
          int'(mode) != m_mode || alarm_on != m_on || alarm_trig != m_trig) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t dut %0d:%0d:%0d alm %0d:%0d mode %0d on %0b trig %0b, model %0d:%0d:%0d alm %0d:%0d mode %0d on %0b trig %0b",
                  $time, cur_hour, cur_min, cur_sec, alm_hour, alm_min, mode, alarm_on, alarm_trig,
                  m_secs / 3600, (m_secs / 60) % 60, m_secs % 60, m_alm / 60, m_alm % 60, m_mode, m_on, m_trig);
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic step(input logic [4:0] v);
      {reset, mode_btn, inc_hour, inc_min, alarm_en_btn} = v;
      @(negedge clk);
      {reset, mode_btn, inc_hour, inc_min, alarm_en_btn} = '0;
      cmp();
   endtask

   task automatic wait_time(input string name, input int mn, input int sc, input int budget);
      int i;
      for (i = 0; i < budget && !(int'(cur_min) == mn && int'(cur_sec) == sc); i++) step('0);
      chk(name, int'(i < budget), 1);
   endtask

   initial begin
      int hi;
      step(RST);
      chk("rst_hour", cur_hour, 0);
      chk("rst_min", cur_min, 0);
      chk("rst_sec", cur_sec, 0);
      chk("rst_alm_hour", alm_hour, 6);
      chk("rst_alm_min", alm_min, 0);
      chk("rst_mode", mode, 0);
      chk("rst_alarm_on", alarm_on, 0);
      chk("rst_trig", alarm_trig, 0);
      step(MB | IH);
      chk("mb_ih_mode", mode, 1);
      chk("mb_ih_hour", cur_hour, 0);
      repeat (61) step(IM);
      repeat (10) step('0);
      chk("set_min", cur_min, 1);
      chk("set_hour", cur_hour, 0);
      chk("set_sec", cur_sec, 0);
      repeat (23) step(IH | IM);
      chk("both_hour", cur_hour, 23);
      chk("both_min", cur_min, 24);
      repeat (35) step(IM);
      chk("load_min", cur_min, 59);
      step(MB);
      step(MB);
      chk("back_run", mode, 0);
      wait_time("wait_59", 59, 59, 300);
      chk("pre_roll_hour", cur_hour, 23);
      wait_time("wait_roll", 0, 0, 5);
      chk("roll_hour", cur_hour, 0);
      chk("roll_min", cur_min, 0);
      chk("roll_sec", cur_sec, 0);
      step(IH | IM);
      chk("run_ignore_hour", cur_hour, 0);
      chk("run_ignore_min", cur_min, 0);
      step(MB);
      step(MB);
      repeat (18) step(IH);
      step(IM);
      chk("alm_hour_set", alm_hour, 0);
      chk("alm_min_set", alm_min, 1);
      step(MB);
      wait_time("wait_0059", 0, 59, 300);
      chk("trig_before", alarm_trig, 0);
      wait_time("wait_0100", 1, 0, 5);
      chk("trig_edge_low", alarm_trig, 0);
      step('0);
      chk("trig_high", alarm_trig, 1);
      hi = 1;
      for (int i = 1; i < 400; i++) begin
         step((i == 10 || i == 20) ? EN : 5'b0);
         if (i == 10) chk("alarm_on_set", alarm_on, 1);
         if (i == 20) chk("alarm_on_clr", alarm_on, 0);
         if (!alarm_trig) break;
         hi++;
      end
      chk("trig_minute_cycles", hi, 240);
      step(MB);
      step(MB);
      repeat (9) step(IH);
      chk("alm_hour_9", alm_hour, 9);
      step(RST | IH);
      chk("rst_sa_mode", mode, 0);
      chk("rst_sa_alm_hour", alm_hour, 6);
      chk("rst_sa_trig", alarm_trig, 0);
      step(MB);
      repeat (3) step(IH);
      chk("mid_set_hour", cur_hour, 3);
      step(RST);
      chk("mid_set_rst_hour", cur_hour, 0);
      chk("mid_set_rst_mode", mode, 0);
      repeat (8) step('0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
